alu_serial_sequencer: RTL and testbench

- Bit-serial initiator that drives one alu_1bit slice over WIDTH cycles.
- Accepts WIDTH-bit operands with opsel/mode/carry-in.
- Presents one operand bit pair per cycle, LSB first, and chains the slice carry through an internal register.
- Collects result bits into a WIDTH-bit word and returns it with the final carry and a done pulse.
- Sits between the control/datapath logic and the single-bit ALU slice.

---
 rtl/alu_serial_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_serial_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_sequencer.sv
// alu_serial_sequencer
//   Bit-serial initiator for a single alu_1bit slice. A WIDTH-bit operation
//   is run over WIDTH cycles. Each cycle presents one operand bit pair to the
//   slice, LSB first, and chains the slice carry through an internal
//   register. The collected result word is returned with the final carry and
//   a one-cycle done pulse.
//
// Optional feature macro: ALU_SERIAL_ZERO_FLAG_EN (adds zero_out).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             request, accepted only when idle
//   op_a, op_b        WIDTH-bit operands, sampled on accepted start
//   opsel_in, mode_in slice operation select / mode, sampled on accepted start
//   cin_in            carry into bit 0, sampled on accepted start
//   busy              high while an operation is in flight (shift + done)
//   done              one-cycle pulse when result_out/cout_out update
//   result_out        assembled result, held until next completion
//   cout_out          slice carry-out of the MSB cycle
//   zero_out          (optional) result was all zeros
//   alu_op1/op2/cin   per-bit slice inputs
//   alu_opsel/mode    latched slice controls
//   alu_result/cout   slice outputs (combinational from alu_*)
module alu_serial_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [2:0]       opsel_in,
   input  logic             mode_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_out,
   output logic             cout_out,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
   output logic             zero_out,
`endif
   output logic             alu_op1,
   output logic             alu_op2,
   output logic             alu_cin,
   output logic [2:0]       alu_opsel,
   output logic             alu_mode,
   input  logic             alu_result,
   input  logic             alu_cout
);

   // Wide enough to hold WIDTH-1.
   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh, b_sh, r_sh;
   logic             carry_r;
   logic [CntW-1:0]  cnt;
   logic [2:0]       opsel_r;
   logic             mode_r;
   logic             last;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
   logic             nz_r;  // any collected result bit was 1
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and outputs
   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      alu_op1   = 1'b0;
      alu_op2   = 1'b0;
      alu_cin   = 1'b0;
      alu_opsel = 3'b000;
      alu_mode  = 1'b0;
      last      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StShift;
         end
         StShift: begin
            busy      = 1'b1;
            alu_op1   = a_sh[0];
            alu_op2   = b_sh[0];
            alu_cin   = carry_r;
            alu_opsel = opsel_r;
            alu_mode  = mode_r;
            last      = (cnt == CntW'(WIDTH - 1));
            if (last) state_d = StDone;
         end
         StDone: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh       <= '0;
         b_sh       <= '0;
         r_sh       <= '0;
         carry_r    <= 1'b0;
         cnt        <= '0;
         opsel_r    <= 3'b000;
         mode_r     <= 1'b0;
         result_out <= '0;
         cout_out   <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
         nz_r       <= 1'b0;
         zero_out   <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  a_sh    <= op_a;
                  b_sh    <= op_b;
                  r_sh    <= '0;
                  carry_r <= cin_in;
                  cnt     <= '0;
                  opsel_r <= opsel_in;
                  mode_r  <= mode_in;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                  nz_r    <= 1'b0;
`endif
               end
            end
            StShift: begin
               r_sh    <= {alu_result, r_sh[WIDTH-1:1]};
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               // Carry is chained in logic mode too; the slice owns its meaning.
               carry_r <= alu_cout;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
               nz_r    <= nz_r | alu_result;
`endif
               if (last) begin
                  result_out <= {alu_result, r_sh[WIDTH-1:1]};
                  cout_out   <= alu_cout;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                  zero_out   <= ~(nz_r | alu_result);
`endif
               end else begin
                  cnt <= cnt + CntW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
module tb_alu_serial_sequencer;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] op_a, op_b;
   logic [2:0]   opsel_in;
   logic         mode_in, cin_in;
   logic         busy, done, cout_out;
   logic [W-1:0] result_out;
   logic         alu_op1, alu_op2, alu_cin, alu_mode;
   logic [2:0]   alu_opsel;
   logic         alu_result, alu_cout;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
   logic         zero_out;
`endif

   int total = 0;
   int bad   = 0;

   // Slice model: full adder.
   assign alu_result = alu_op1 ^ alu_op2 ^ alu_cin;
   assign alu_cout   = (alu_op1 & alu_op2) | (alu_op1 & alu_cin) | (alu_op2 & alu_cin);

   alu_serial_sequencer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op_a       (op_a),
      .op_b       (op_b),
      .opsel_in   (opsel_in),
      .mode_in    (mode_in),
      .cin_in     (cin_in),
      .busy       (busy),
      .done       (done),
      .result_out (result_out),
      .cout_out   (cout_out),
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      .zero_out   (zero_out),
`endif
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_cin    (alu_cin),
      .alu_opsel  (alu_opsel),
      .alu_mode   (alu_mode),
      .alu_result (alu_result),
      .alu_cout   (alu_cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [2:0]   opsel;
      logic         mode;
      logic [W-1:0] res;
      logic         cout;
      bit           noisy;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_quiet(input string tag, input logic [W-1:0] exp_res, input logic exp_cout);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_result"}, 32'(result_out), 32'(exp_res));
      check({tag, "_cout"}, 32'(cout_out), 32'(exp_cout));
      check({tag, "_alu"}, 32'({alu_op1, alu_op2, alu_cin, alu_opsel, alu_mode}), 32'd0);
   endtask

   task automatic run_op(input vec_t v);
      int   cycles;
      logic ctrl_ok;
      @(negedge clk);
      op_a = v.a; op_b = v.b; cin_in = v.cin; opsel_in = v.opsel; mode_in = v.mode;
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      cycles  = 0;
      ctrl_ok = 1'b1;
      while (done !== 1'b1 && cycles < 20) begin
         if (busy !== 1'b1 || alu_opsel !== v.opsel || alu_mode !== v.mode) ctrl_ok = 1'b0;
         if (v.noisy) begin
            start    = 1'b1;
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            cin_in   = ~v.cin;
            opsel_in = ~v.opsel;
            mode_in  = ~v.mode;
         end
         cycles++;
         @(negedge clk);
      end
      start = 1'b0;
      check("shift_cycles", 32'(cycles), 32'(W));
      check("shift_ctrl_stable", 32'(ctrl_ok), 32'd1);
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd1);
      check("result", 32'(result_out), 32'(v.res));
      check("cout", 32'(cout_out), 32'(v.cout));
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      check("zero", 32'(zero_out), 32'(v.res == '0));
`endif
      @(negedge clk);
      check_quiet("after_done", v.res, v.cout);
      // A stray accept under noisy start would show up here as busy.
      @(negedge clk);
      check("idle_stays", 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0] = '{a: 8'h3C, b: 8'h5A, cin: 1'b0, opsel: 3'b010, mode: 1'b0,
                  res: 8'h96, cout: 1'b0, noisy: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, opsel: 3'b000, mode: 1'b0,
                  res: 8'h00, cout: 1'b1, noisy: 1'b0};
      vecs[2] = '{a: 8'h00, b: 8'h00, cin: 1'b1, opsel: 3'b001, mode: 1'b0,
                  res: 8'h01, cout: 1'b0, noisy: 1'b1};
      vecs[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, opsel: 3'b111, mode: 1'b1,
                  res: 8'h00, cout: 1'b1, noisy: 1'b0};
      vecs[4] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, opsel: 3'b101, mode: 1'b0,
                  res: 8'h00, cout: 1'b1, noisy: 1'b0};
      vecs[5] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, opsel: 3'b011, mode: 1'b1,
                  res: 8'h80, cout: 1'b0, noisy: 1'b0};
      vecs[6] = '{a: 8'h12, b: 8'h34, cin: 1'b1, opsel: 3'b110, mode: 1'b0,
                  res: 8'h47, cout: 1'b0, noisy: 1'b0};

      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
      opsel_in = 3'b000; mode_in = 1'b0; cin_in = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_quiet("reset_idle", 8'h00, 1'b0);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      check("reset_zero", 32'(zero_out), 32'd0);
`endif

      for (int i = 0; i < 7; i++) run_op(vecs[i]);

      // Reset in the 4th shift cycle of 0x3C+0x5A; result_out currently 0x47.
      @(negedge clk);
      op_a = 8'h3C; op_b = 8'h5A; cin_in = 1'b0; opsel_in = 3'b010; mode_in = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_op_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_quiet("mid_reset", 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      run_op('{a: 8'h10, b: 8'h20, cin: 1'b0, opsel: 3'b000, mode: 1'b0,
               res: 8'h30, cout: 1'b0, noisy: 1'b0});

      // Back-to-back with start held high.
      begin
         int last_done = -1;
         int n_done    = 0;
         logic stable  = 1'b1;
         @(negedge clk);
         op_a = 8'h3C; op_b = 8'h5A; cin_in = 1'b0; opsel_in = 3'b010; mode_in = 1'b0;
         start = 1'b1;
         for (int c = 0; c < 42; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
               if (last_done >= 0) check("b2b_gap", 32'(c - last_done), 32'(W + 2));
               check("b2b_result", 32'(result_out), 32'h96);
               last_done = c;
               n_done++;
            end else if (last_done >= 0 && result_out !== 8'h96) begin
               stable = 1'b0;
            end
         end
         start = 1'b0;
         check("b2b_count_min3", 32'(n_done >= 3), 32'd1);
         check("b2b_stable", 32'(stable), 32'd1);
         for (int c = 0; c < 12 && busy === 1'b1; c++) @(negedge clk);
         check("b2b_drain_idle", 32'(busy), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
